// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the FSM state encoding and the length-byte interpretation.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // A length byte of zero encodes a full 256-byte image.
  localparam logic [8:0] LEN_ZERO_MEANS_256 = 9'd256;

endpackage

// File: rtl/xor_acc8.sv
// 8-bit XOR accumulator with synchronous clear and enable.
// Clear has priority over enable.
module xor_acc8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed image from a host byte link
// into instruction memory while holding the CPU in reset.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rom_wr_addr,
  output logic [7:0] rom_wr_data,
  output logic       rom_n_cs,
  output logic       rom_n_we,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  state_t      state, state_nxt;
  logic [8:0]  cnt;
  logic [7:0]  acc;
  logic        acc_clr, ld_len, ld_data, do_write;

  xor_acc8 u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (ld_data),
    .din   (in_data),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rom_n_cs  = 1'b1;
    rom_n_we  = 1'b1;
    acc_clr   = 1'b0;
    ld_len    = 1'b0;
    ld_data   = 1'b0;
    do_write  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt = ST_LEN;
          acc_clr   = 1'b1;
        end
      end
      ST_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_len    = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_data   = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        rom_n_cs  = 1'b0;
        rom_n_we  = 1'b0;
        do_write  = 1'b1;
        state_nxt = (cnt == 9'd1) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == acc) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address, data and remaining-count registers; all return to their load defaults on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_wr_addr <= START_ADDR;
      rom_wr_data <= '0;
      cnt         <= '0;
    end else begin
      if (acc_clr) rom_wr_addr <= START_ADDR;
      if (ld_len)  cnt <= (in_data == 8'h00) ? LEN_ZERO_MEANS_256 : {1'b0, in_data};
      if (ld_data) rom_wr_data <= in_data;
      if (do_write) begin
        rom_wr_addr <= rom_wr_addr + 8'd1;
        cnt         <= cnt - 9'd1;
      end
    end
  end

  assign load_done = (state == ST_DONE);
  assign load_err  = (state == ST_ERR);
  assign cpu_hold  = (state != ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (START_ADDR 00 and FE)
// share stimulus; each write strobe is checked against queued expectations.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       in_ready, rom_n_cs, rom_n_we, cpu_hold, load_done, load_err;
  logic [7:0] rom_wr_addr, rom_wr_data;
  logic       f_in_ready, f_rom_n_cs, f_rom_n_we, f_cpu_hold, f_load_done, f_load_err;
  logic [7:0] f_rom_wr_addr, f_rom_wr_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] q0 [$];
  logic [15:0] qf [$];
  logic [7:0]  a0, af;
  logic [7:0]  pay [$];

  always #5 clk = ~clk;

  prog_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data),
    .rom_n_cs(rom_n_cs), .rom_n_we(rom_n_we), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  prog_loader #(.START_ADDR(8'hFE)) u_dut_fe (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(f_in_ready), .rom_wr_addr(f_rom_wr_addr), .rom_wr_data(f_rom_wr_data),
    .rom_n_cs(f_rom_n_cs), .rom_n_we(f_rom_n_we), .cpu_hold(f_cpu_hold),
    .load_done(f_load_done), .load_err(f_load_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-strobe monitors, one per instance.
  always @(negedge clk) begin
    if (!rom_n_cs) begin
      chk("n_we_with_cs", rom_n_we, 0);
      if (q0.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        logic [15:0] e;
        e = q0.pop_front();
        chk("wr_addr", rom_wr_addr, e[15:8]);
        chk("wr_data", rom_wr_data, e[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!f_rom_n_cs) begin
      chk("fe_n_we_with_cs", f_rom_n_we, 0);
      if (qf.size() == 0) chk("fe_unexpected_wr", 1, 0);
      else begin
        logic [15:0] e;
        e = qf.pop_front();
        chk("fe_wr_addr", f_rom_wr_addr, e[15:8]);
        chk("fe_wr_data", f_rom_wr_data, e[7:0]);
      end
    end
  end

  task automatic push_wr(input logic [7:0] b);
    q0.push_back({a0, b});
    qf.push_back({af, b});
    a0 = a0 + 8'd1;
    af = af + 8'd1;
  endtask

  // Called at a negedge; returns at a negedge with in_valid low.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a0 = 8'h00;
    af = 8'hFE;
  endtask

  task automatic run_load(input logic [7:0] len_b, input logic [7:0] cs, input bit rnd);
    start_load();
    send_byte(len_b);
    for (int i = 0; i < pay.size(); i++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (i == 1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      push_wr(pay[i]);
      send_byte(pay[i]);
    end
    @(negedge clk);
    send_byte(cs);
  endtask

  task automatic check_final(input string tag, input logic done, input logic err);
    chk({tag, "_done"}, load_done, done);
    chk({tag, "_err"}, load_err, err);
    chk({tag, "_hold"}, cpu_hold, !done);
    chk({tag, "_fe_done"}, f_load_done, done);
    chk({tag, "_fe_hold"}, f_cpu_hold, !done);
    chk({tag, "_q_empty"}, q0.size(), 0);
    chk({tag, "_fe_q_empty"}, qf.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_n_cs"}, rom_n_cs, 1);
    chk({tag, "_n_we"}, rom_n_we, 1);
    chk({tag, "_addr"}, rom_wr_addr, 8'h00);
    chk({tag, "_data"}, rom_wr_data, 8'h00);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, load_err, 0);
    chk({tag, "_fe_addr"}, f_rom_wr_addr, 8'hFE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    // Three-byte load with good checksum.
    pay = '{8'h11, 8'h22, 8'h44};
    run_load(8'h03, 8'h77, 1'b0);
    check_final("good3", 1'b1, 1'b0);

    // Same load, wrong checksum.
    run_load(8'h03, 8'h00, 1'b0);
    check_final("bad3", 1'b0, 1'b1);

    // Full 256-byte image; XOR of 0..255 is zero.
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(i[7:0]);
    run_load(8'h00, 8'h00, 1'b0);
    check_final("len256", 1'b1, 1'b0);
    chk("len256_addr_wrap", rom_wr_addr, 8'h00);
    chk("len256_fe_addr_wrap", f_rom_wr_addr, 8'hFE);
    chk("len256_last_data", rom_wr_data, 8'hFF);

    // Random in_valid gaps plus an ignored start pulse mid-load.
    pay = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    run_load(8'h04, 8'hA5 ^ 8'h3C ^ 8'h0F ^ 8'hF0, 1'b1);
    check_final("rnd4", 1'b1, 1'b0);

    // Reset during the write cycle of the second data byte.
    start_load();
    send_byte(8'h03);
    push_wr(8'h55);
    send_byte(8'h55);
    @(negedge clk);
    in_data  = 8'h66;
    in_valid = 1'b1;
    begin
      int n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk("rst_mid_timeout", 0, 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    chk("rst_mid_q_empty", q0.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid_after");

    // Recovery load after the interrupted one.
    pay = '{8'h01, 8'h02, 8'h04};
    run_load(8'h03, 8'h07, 1'b0);
    check_final("recover", 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
